uart_tx_stream: RTL and testbench



---
 rtl/uart_tx_stream_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_tx_stream.sv | 140 ++++++++++++++
 tb/tb_uart_tx_stream.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_stream_pkg.sv
// Shared definitions for the UART transmit path: shifter state encoding and counter sizing.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_tx_stream_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } tx_state_e;
`endif

  // Smallest width that can hold the values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1, pulses tick_o on DIV-1, and holds at 0 while restart_i is high.
module uart_baud_tick
  import uart_tx_stream_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned W = clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || restart_i) cnt_q <= '0;
    else if (tick_o)      cnt_q <= '0;
    else                  cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Byte-stream to UART serialiser: one-byte holding register feeding a shift FSM, frames back to back.
// Define UART_TX_PARITY_EN to append an even-parity bit between the data bits and the stop bit(s).
module uart_tx_stream
  import uart_tx_stream_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       require,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned DIV       = CLK_FREQ / BAUD_RATE;
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  logic       hold_full_q, hold_full_d;
  logic [7:0] hold_data_q, hold_data_d;
  tx_state_e  state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_idx_q;
  logic       stop_cnt_q;
  logic       txd_q;
  logic       tick, baud_restart, frame_end, load;
`ifdef UART_TX_PARITY_EN
  logic       parity_q;
`endif

  assign require      = valid & ~hold_full_q & ~rst;
  assign frame_end    = (state_q == ST_STOP) & tick & (stop_cnt_q == STOP_LAST);
  assign load         = hold_full_q & ((state_q == ST_IDLE) | frame_end);
  assign baud_restart = (state_q == ST_IDLE);
  assign txd          = txd_q;
  assign busy         = (state_q != ST_IDLE) | hold_full_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (require) begin
      hold_full_d = 1'b1;
      hold_data_d = data;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_full_q <= 1'b0;
    else     hold_full_q <= hold_full_d;
  end

  // NOTE: payload registers carry no reset; their contents are only used once a
  // valid flag or FSM state that is reset says they are meaningful.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    if (load) begin
      shift_q  <= hold_data_q;
`ifdef UART_TX_PARITY_EN
      parity_q <= ^hold_data_q;
`endif
    end else if (state_q == ST_DATA && tick) begin
      shift_q <= shift_q >> 1;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart_i(baud_restart),
    .tick_o   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      txd_q      <= 1'b1;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (load) begin
          state_q <= ST_START;
          txd_q   <= 1'b0;
        end
        ST_START: if (tick) begin
          state_q   <= ST_DATA;
          txd_q     <= shift_q[0];
          bit_idx_q <= 3'd0;
        end
        ST_DATA: if (tick) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_q    <= ST_PARITY;
            txd_q      <= parity_q;
`else
            state_q    <= ST_STOP;
            txd_q      <= 1'b1;
            stop_cnt_q <= 1'b0;
`endif
          end else begin
            bit_idx_q <= bit_idx_q + 3'd1;
            txd_q     <= shift_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (tick) begin
          state_q    <= ST_STOP;
          txd_q      <= 1'b1;
          stop_cnt_q <= 1'b0;
        end
`endif
        ST_STOP: if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            stop_cnt_q <= 1'b0;
            // A queued byte starts on the very next bit period: no idle gap.
            if (hold_full_q) begin
              state_q <= ST_START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            stop_cnt_q <= stop_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at DIV=4: one instance with one stop bit, one with two.
module tb_uart_tx_stream;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS1 = 11;
`else
  localparam int FRAME_BITS1 = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       require1, require2;
  logic       txd1, txd2;
  logic       busy1, busy2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int n_req1 = 0;
  int req_cyc[4];
  int first_low;
  logic [7:0] src_bytes[4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (require1 === 1'b1) n_req1 <= n_req1 + 1;
  end

  uart_tx_stream #(.CLK_FREQ(40), .BAUD_RATE(10), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .data(data1), .valid(valid1),
    .require(require1), .txd(txd1), .busy(busy1)
  );

  uart_tx_stream #(.CLK_FREQ(40), .BAUD_RATE(10), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .data(data2), .valid(valid2),
    .require(require2), .txd(txd2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers src_bytes[0..n-1] with valid held high; records the cycle of each require.
  task automatic send_stream(input bit sel, input int n);
    int budget;
    for (int i = 0; i < n; i++) begin
      if (sel) begin data2 = src_bytes[i]; valid2 = 1'b1; end
      else     begin data1 = src_bytes[i]; valid1 = 1'b1; end
      budget = 0;
      #1;
      while (((sel ? require2 : require1) !== 1'b1) && budget < 200) begin
        @(negedge clk);
        #1;
        budget++;
      end
      check($sformatf("req_seen_%0d", i), sel ? require2 : require1, 1);
      req_cyc[i] = cyc_cnt;
      @(negedge clk);
    end
    if (sel) valid2 = 1'b0;
    else     valid1 = 1'b0;
  endtask

  task automatic wait_start(input bit sel);
    int budget;
    budget = 0;
    while (((sel ? txd2 : txd1) !== 1'b0) && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    check("start_seen", sel ? txd2 : txd1, 0);
    first_low = cyc_cnt;
  endtask

  // Checks every cycle of one frame; returns on the negedge just after its last stop cycle.
  task automatic expect_frame(input bit sel, input logic [7:0] b, input string tag);
    logic exp_bits[$];
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(^b);
`endif
    for (int s = 0; s < (sel ? 2 : 1); s++) exp_bits.push_back(1'b1);
    foreach (exp_bits[k]) begin
      check($sformatf("%s_busy%0d", tag, k), sel ? busy2 : busy1, 1);
      repeat (DIV) begin
        check($sformatf("%s_bit%0d", tag, k), sel ? txd2 : txd1, exp_bits[k]);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int req_base;
    rst = 1'b1; valid1 = 1'b0; valid2 = 1'b0; data1 = '0; data2 = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    valid1 = 1'b1; data1 = 8'hFF;
    #1;
    check("req_in_reset", require1, 0);
    check("txd_reset", txd1, 1);
    check("busy_reset", busy1, 0);
    check("txd2_reset", txd2, 1);
    check("busy2_reset", busy2, 0);
    @(negedge clk);
    valid1 = 1'b0; rst = 1'b0;
    #1;
    check("req_no_valid", require1, 0);
    @(negedge clk);

    // Single byte 'A'
    src_bytes[0] = 8'h41;
    fork
      send_stream(1'b0, 1);
      begin wait_start(1'b0); expect_frame(1'b0, 8'h41, "a41"); end
    join
    check("a41_latency", first_low - req_cyc[0], 2);
    check("a41_txd_idle", txd1, 1);
    check("a41_busy_done", busy1, 0);

    // Back-to-back "ok\n" with valid held high, third byte back-pressured
    req_base = n_req1;
    src_bytes[0] = 8'h6F; src_bytes[1] = 8'h6B; src_bytes[2] = 8'h0A;
    fork
      send_stream(1'b0, 3);
      begin
        wait_start(1'b0);
        expect_frame(1'b0, 8'h6F, "ok_o");
        expect_frame(1'b0, 8'h6B, "ok_k");
        expect_frame(1'b0, 8'h0A, "ok_nl");
      end
    join
    check("ok_latency", first_low - req_cyc[0], 2);
    check("ok_req2_gap", req_cyc[1] - req_cyc[0], 2);
    check("ok_req3_at_load", req_cyc[2] - first_low, DIV * FRAME_BITS1);
    check("ok_req_count", n_req1 - req_base, 3);
    check("ok_txd_idle", txd1, 1);
    check("ok_busy_done", busy1, 0);

    // Reset during data bit 3 of 0xA5 with 0xC3 waiting in the holding register
    src_bytes[0] = 8'hA5; src_bytes[1] = 8'hC3;
    fork
      send_stream(1'b0, 2);
      begin
        wait_start(1'b0);
        repeat (17) @(negedge clk);
        check("a5_bit3", txd1, 0);
        check("a5_held", busy1, 1);
        rst = 1'b1;
        @(negedge clk);
      end
    join
    check("rst_txd", txd1, 1);
    check("rst_busy", busy1, 0);
    valid1 = 1'b1; data1 = 8'h99;
    #1;
    check("rst_req", require1, 0);
    valid1 = 1'b0; rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("rst_discard_txd", txd1, 1);
      check("rst_discard_busy", busy1, 0);
    end
    src_bytes[0] = 8'h5A;
    fork
      send_stream(1'b0, 1);
      begin wait_start(1'b0); expect_frame(1'b0, 8'h5A, "a5a"); end
    join
    check("a5a_busy_done", busy1, 0);

    // Parity candidates: 0x07 (odd weight) and 0x03 (even weight)
    src_bytes[0] = 8'h07; src_bytes[1] = 8'h03;
    fork
      send_stream(1'b0, 2);
      begin
        wait_start(1'b0);
        expect_frame(1'b0, 8'h07, "p07");
        expect_frame(1'b0, 8'h03, "p03");
      end
    join
    check("par_txd_idle", txd1, 1);
    check("par_busy_done", busy1, 0);

    // Two stop bits with a queued byte
    src_bytes[0] = 8'h55; src_bytes[1] = 8'h81;
    fork
      send_stream(1'b1, 2);
      begin
        wait_start(1'b1);
        expect_frame(1'b1, 8'h55, "s2_55");
        expect_frame(1'b1, 8'h81, "s2_81");
      end
    join
    check("s2_txd_idle", txd2, 1);
    check("s2_busy_done", busy2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
